noc_rx_port: RTL and testbench

NOC_RX_PORT -- requirements
Module: noc_rx_port

---
 rtl/noc_rx_port.sv | 65 ++++++
 tb/tb_noc_rx_port.sv | 111 +++++++++++
 2 files changed

// File: rtl/noc_rx_port.sv
// noc_rx_port: 4-entry first-word-fall-through receive FIFO between one NOC output port and a local core,
// with overflow drop counting and sticky per-source seen flags.
module noc_rx_port (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic [7:0] port_in,
    input  logic       en_in,
    input  logic [1:0] src_add,
    output logic       full,
    output logic [7:0] out_data,
    output logic [1:0] out_src,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] drop_cnt,
    output logic [3:0] src_seen
);
    logic [9:0] mem_q [4];
    logic [9:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] drop_q, drop_d;
    logic [3:0] seen_q, seen_d;
    logic       wr_req, rd, wr, drop;

    assign full      = cnt_q == 3'd4;
    assign out_valid = cnt_q != 3'd0;
    assign {out_src, out_data} = mem_q[rd_ptr_q];
    assign drop_cnt  = drop_q;
    assign src_seen  = seen_q;

    assign wr_req = CS & en_in;
    assign rd     = out_valid & out_ready;
    // when full, a same-cycle read frees the head slot, which is exactly where wr_ptr points
    assign wr     = wr_req & (~full | rd);
    assign drop   = wr_req & full & ~rd;

    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wr_ptr_q] = {src_add, port_in};
        wr_ptr_d = wr ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + 2'd1 : rd_ptr_q;
        cnt_d    = (wr & ~rd) ? cnt_q + 3'd1 : (rd & ~wr) ? cnt_q - 3'd1 : cnt_q;
        drop_d   = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
        seen_d   = wr ? seen_q | (4'b0001 << src_add) : seen_q;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
            seen_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            seen_q   <= seen_d;
        end
    end
endmodule

// File: tb/tb_noc_rx_port.sv
// tb_noc_rx_port: table-driven directed checks of noc_rx_port plus a drop-counter saturation sequence.
module tb_noc_rx_port;
    logic       CLK = 0, RES, CS, en_in, out_ready;
    logic [7:0] port_in, out_data, drop_cnt;
    logic [1:0] src_add, out_src;
    logic       full, out_valid;
    logic [3:0] src_seen;
    int checks = 0, errors = 0;

    noc_rx_port dut (
        .CLK(CLK), .RES(RES), .CS(CS), .port_in(port_in), .en_in(en_in), .src_add(src_add),
        .full(full), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt), .src_seen(src_seen)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       res, cs, en;
        logic [7:0] pin;
        logic [1:0] src;
        logic       rdy;
        logic       e_full, e_valid, dck;
        logic [7:0] e_data;
        logic [1:0] e_src;
        logic [7:0] e_drop;
        logic [3:0] e_seen;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t v(logic res, logic cs, logic en, logic [7:0] pin, logic [1:0] src, logic rdy,
                               logic e_full, logic e_valid, logic dck, logic [7:0] e_data, logic [1:0] e_src,
                               logic [7:0] e_drop, logic [3:0] e_seen);
        vec_t r;
        r.res = res; r.cs = cs; r.en = en; r.pin = pin; r.src = src; r.rdy = rdy;
        r.e_full = e_full; r.e_valid = e_valid; r.dck = dck; r.e_data = e_data;
        r.e_src = e_src; r.e_drop = e_drop; r.e_seen = e_seen;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(logic res, logic cs, logic en, logic [7:0] pin, logic [1:0] src, logic rdy);
        RES = res; CS = cs; en_in = en; port_in = pin; src_add = src; out_ready = rdy;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //                res cs en pin src rdy  full valid dck data osrc drop seen
        vecs[0]  = v(1, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 4'b0000);
        vecs[1]  = v(0, 1, 1, 20, 1, 0,  0, 1, 1, 20, 1, 0, 4'b0010);
        vecs[2]  = v(1, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 4'b0000);
        vecs[3]  = v(0, 1, 1, 25, 0, 0,  0, 1, 1, 25, 0, 0, 4'b0001);
        vecs[4]  = v(0, 1, 1, 35, 1, 0,  0, 1, 1, 25, 0, 0, 4'b0011);
        vecs[5]  = v(0, 1, 1, 45, 2, 0,  0, 1, 1, 25, 0, 0, 4'b0111);
        vecs[6]  = v(0, 1, 1, 56, 3, 0,  1, 1, 1, 25, 0, 0, 4'b1111);
        vecs[7]  = v(0, 1, 1, 99, 0, 0,  1, 1, 1, 25, 0, 1, 4'b1111);
        vecs[8]  = v(0, 1, 1, 77, 2, 1,  1, 1, 1, 35, 1, 1, 4'b1111);
        vecs[9]  = v(0, 0, 0,  0, 0, 1,  0, 1, 1, 45, 2, 1, 4'b1111);
        vecs[10] = v(0, 0, 0,  0, 0, 1,  0, 1, 1, 56, 3, 1, 4'b1111);
        vecs[11] = v(0, 0, 0,  0, 0, 1,  0, 1, 1, 77, 2, 1, 4'b1111);
        vecs[12] = v(0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 0, 1, 4'b1111);
        vecs[13] = v(0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 0, 1, 4'b1111);
        vecs[14] = v(1, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 4'b0000);
        vecs[15] = v(0, 0, 1, 11, 2, 0,  0, 0, 1,  0, 0, 0, 4'b0000);
        vecs[16] = v(0, 0, 1, 12, 3, 0,  0, 0, 1,  0, 0, 0, 4'b0000);
        vecs[17] = v(0, 0, 1, 13, 1, 0,  0, 0, 1,  0, 0, 0, 4'b0000);
        vecs[18] = v(0, 1, 1,  1, 0, 0,  0, 1, 1,  1, 0, 0, 4'b0001);
        vecs[19] = v(0, 1, 1,  2, 1, 0,  0, 1, 1,  1, 0, 0, 4'b0011);
        vecs[20] = v(1, 1, 1,  3, 2, 1,  0, 0, 1,  0, 0, 0, 4'b0000);

        RES = 1; CS = 0; en_in = 0; port_in = 0; src_add = 0; out_ready = 0;
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].res, vecs[i].cs, vecs[i].en, vecs[i].pin, vecs[i].src, vecs[i].rdy);
            chk("full", i, full, vecs[i].e_full);
            chk("out_valid", i, out_valid, vecs[i].e_valid);
            if (vecs[i].dck) begin
                chk("out_data", i, out_data, vecs[i].e_data);
                chk("out_src", i, out_src, vecs[i].e_src);
            end
            chk("drop_cnt", i, drop_cnt, vecs[i].e_drop);
            chk("src_seen", i, src_seen, vecs[i].e_seen);
        end

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 8'(100 + i), 2'(i), 0);
        chk("sat_full", 100, full, 1);
        for (int i = 0; i < 260; i++) begin
            step(0, 1, 1, 8'(i), 2'(i), 0);
            if (i == 0) chk("sat_first", 101, drop_cnt, 1);
            if (i == 254) chk("sat_255", 102, drop_cnt, 255);
        end
        chk("sat_end", 103, drop_cnt, 255);
        chk("sat_head", 104, out_data, 100);
        chk("sat_full_end", 105, full, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("sat_pop", 106, out_data, 101);
        chk("sat_pop_full", 107, full, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
